// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: frame-capture sequencer in the camera pixel-clock domain.
// It gates the buffer RAM write enable so that only whole, vsync-aligned
// frames are written, either one snapshot at a time or continuously. It also
// counts pixels and lines per frame and flags short and long frames.
//
// Optional watchdog: define CAPTURE_WDOG_EN to add a cycle counter that aborts
// ARM/CAPTURE after TIMEOUT_CYC cycles without a vsync edge. It also adds the
// sticky err_timeout output. Without the macro, ARM and CAPTURE wait forever.
module cam_capture_ctrl #(
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120,
    parameter int AW           = 15,
    parameter int TIMEOUT_CYC  = 2000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic          pix_valid_in,
    input  logic          snap,
    input  logic          cont_mode,
    output logic          DP_RAM_regW,
    output logic          busy,
    output logic          frame_done,
    output logic [7:0]    frame_cnt,
    output logic [AW-1:0] pix_cnt,
    output logic [7:0]    line_cnt,
    output logic          err_short,
    output logic          err_long
`ifdef CAPTURE_WDOG_EN
    ,
    output logic          err_timeout
`endif
);

    localparam int            IMA_SIZ   = CAM_SCREEN_X * CAM_SCREEN_Y;
    localparam logic [AW-1:0] IMA_SIZ_W = AW'(IMA_SIZ);

    // The frame size must fit the address width and the watchdog needs a usable limit
    if ((IMA_SIZ >= (2 ** AW)) || (TIMEOUT_CYC < 2)) begin : g_bad_params
        $error("cam_capture_ctrl: frame size does not fit AW or TIMEOUT_CYC < 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          vsync_q;
    logic          href_q;
    logic          vs_fall;
    logic          vs_rise;
    logic          href_fall;
    logic          pix_accept;
    logic [AW-1:0] pix_cnt_inc;
    logic          wdog_hit;

    assign vs_fall     = vsync_q & ~CAM_vsync;
    assign vs_rise     = ~vsync_q & CAM_vsync;
    assign href_fall   = href_q & ~CAM_href;
    assign pix_accept  = (state_q == CAPTURE) & pix_valid_in & (pix_cnt < IMA_SIZ_W);
    assign pix_cnt_inc = pix_cnt + AW'(1);

    assign DP_RAM_regW = pix_accept & ~rst;
    assign busy        = (state_q == ARM) | (state_q == CAPTURE);
    assign frame_done  = (state_q == DONE);

    // Delay vsync/href by one cycle for edge detection; vsync idles high between frames
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b1;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= CAM_vsync;
            href_q  <= CAM_href;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: arm on request, capture between vsync fall and rise
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (snap | cont_mode) state_d = ARM;
            ARM:     if (vs_fall)          state_d = CAPTURE;
            CAPTURE: if (vs_rise)          state_d = DONE;
            DONE:    state_d = (snap | cont_mode) ? ARM : IDLE;
            default: state_d = IDLE;
        endcase
        if (wdog_hit) begin
            state_d = IDLE;
        end
    end

    // Per-frame counters and flags, cleared on CAPTURE entry and held until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt   <= '0;
            line_cnt  <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if ((state_q == ARM) && (state_d == CAPTURE)) begin
                pix_cnt   <= '0;
                line_cnt  <= '0;
                err_short <= 1'b0;
                err_long  <= 1'b0;
            end else if (state_q == CAPTURE) begin
                if (pix_accept) begin
                    pix_cnt <= pix_cnt_inc;
                end else if (pix_valid_in) begin
                    err_long <= 1'b1;
                end
                if (href_fall && (line_cnt != 8'hFF)) begin
                    line_cnt <= line_cnt + 8'd1;
                end
                if (vs_rise) begin
                    err_short <= ((pix_accept ? pix_cnt_inc : pix_cnt) < IMA_SIZ_W);
                end
            end
            if ((state_q == CAPTURE) && (state_d == DONE)) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

`ifdef CAPTURE_WDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYC);

    logic [WDOG_W-1:0] wdog_cnt;

    assign wdog_hit = busy & ~(vs_fall | vs_rise) & (wdog_cnt == WDOG_W'(TIMEOUT_CYC - 1));

    // Watchdog counts idle cycles between vsync edges and latches a sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (!busy || vs_fall || vs_rise || wdog_hit) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
            if (wdog_hit) begin
                err_timeout <= 1'b1;
            end else if ((state_d == ARM) && (state_q != ARM)) begin
                err_timeout <= 1'b0;
            end
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: randomized self-checking bench for cam_capture_ctrl.
// The frame model predicts writes, counters and flags from pixel/line totals.
`timescale 1ns/1ps
module tb_cam_capture_ctrl;

    localparam int X   = 4;
    localparam int Y   = 3;
    localparam int AW  = 15;
    localparam int TMO = 50;
    localparam int IMA = X * Y;

    logic          clk          = 1'b0;
    logic          rst          = 1'b1;
    logic          CAM_vsync    = 1'b1;
    logic          CAM_href     = 1'b0;
    logic          pix_valid_in = 1'b0;
    logic          snap         = 1'b0;
    logic          cont_mode    = 1'b0;
    logic          DP_RAM_regW;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_cnt;
    logic [AW-1:0] pix_cnt;
    logic [7:0]    line_cnt;
    logic          err_short;
    logic          err_long;
`ifdef CAPTURE_WDOG_EN
    logic          err_timeout;
`endif

    int errors        = 0;
    int checks        = 0;
    int wr_count      = 0;
    int done_count    = 0;
    int exp_frame_cnt = 0;

    typedef struct {
        int wr;
        int pix;
        int lines;
        bit short_f;
        bit long_f;
    } frame_exp_t;

    cam_capture_ctrl #(
        .CAM_SCREEN_X(X),
        .CAM_SCREEN_Y(Y),
        .AW(AW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .CAM_vsync(CAM_vsync),
        .CAM_href(CAM_href),
        .pix_valid_in(pix_valid_in),
        .snap(snap),
        .cont_mode(cont_mode),
        .DP_RAM_regW(DP_RAM_regW),
        .busy(busy),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt),
        .pix_cnt(pix_cnt),
        .line_cnt(line_cnt),
        .err_short(err_short),
        .err_long(err_long)
`ifdef CAPTURE_WDOG_EN
        ,
        .err_timeout(err_timeout)
`endif
    );

    always #5 clk = ~clk;

    // Count RAM writes and done pulses mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (DP_RAM_regW === 1'b1) wr_count++;
        if (frame_done === 1'b1) done_count++;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    // Expected result of one captured frame from delivered pixel and line totals
    function automatic frame_exp_t model_frame(input int n, input int l);
        frame_exp_t e;
        e.wr      = (n < IMA) ? n : IMA;
        e.pix     = e.wr;
        e.lines   = (l > 255) ? 255 : l;
        e.short_f = (n < IMA);
        e.long_f  = (n > IMA);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_snap();
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    task automatic frame_start();
        CAM_vsync = 1'b1;
        repeat ($urandom_range(2, 4)) tick();
        CAM_vsync = 1'b0;
        tick();
        repeat ($urandom_range(1, 2)) tick();
    endtask

    task automatic frame_body(input int lines, input int ppl, input int extra, output int delivered);
        delivered = 0;
        for (int l = 0; l < lines; l++) begin
            int n;
            n = (l == lines - 1) ? ppl + extra : ppl;
            CAM_href = 1'b1;
            for (int p = 0; p < n; p++) begin
                pix_valid_in = 1'b0;
                repeat ($urandom_range(0, 1)) tick();
                pix_valid_in = 1'b1;
                tick();
                delivered++;
            end
            pix_valid_in = 1'b0;
            CAM_href     = 1'b0;
            tick();
            repeat ($urandom_range(1, 2)) tick();
        end
    endtask

    task automatic frame_end();
        CAM_vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (DP_RAM_regW !== 1'b0) begin errors++; $display("[TB] FAIL reset_regw_in_rst: got %b want 0", DP_RAM_regW); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", frame_done); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        checks++; if (pix_cnt !== '0) begin errors++; $display("[TB] FAIL reset_pix_cnt: got %0d want 0", pix_cnt); end
        checks++; if (line_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_line_cnt: got %0d want 0", line_cnt); end
        checks++; if (err_short !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_short: got %b want 0", err_short); end
        checks++; if (err_long !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_long: got %b want 0", err_long); end
        exp_frame_cnt = 0;
    endtask

    task automatic test_snapshot();
        int w0, d0, n;
        frame_exp_t fe;
        w0 = wr_count; d0 = done_count;
        pulse_snap();
        frame_start();
        frame_body(Y, X, 0, n);
        frame_end();
        fe = model_frame(n, Y);
        exp_frame_cnt = (exp_frame_cnt + 1) % 256;
        checks++; if (wr_count - w0 !== fe.wr) begin errors++; $display("[TB] FAIL snap_writes: got %0d want %0d", wr_count - w0, fe.wr); end
        checks++; if (done_count - d0 !== 1) begin errors++; $display("[TB] FAIL snap_done: got %0d want 1", done_count - d0); end
        checks++; if (int'(frame_cnt) !== exp_frame_cnt) begin errors++; $display("[TB] FAIL snap_frame_cnt: got %0d want %0d", frame_cnt, exp_frame_cnt); end
        checks++; if (int'(pix_cnt) !== fe.pix) begin errors++; $display("[TB] FAIL snap_pix_cnt: got %0d want %0d", pix_cnt, fe.pix); end
        checks++; if (int'(line_cnt) !== fe.lines) begin errors++; $display("[TB] FAIL snap_line_cnt: got %0d want %0d", line_cnt, fe.lines); end
        checks++; if (err_short !== fe.short_f || err_long !== fe.long_f) begin errors++; $display("[TB] FAIL snap_errs: got %b%b want %b%b", err_short, err_long, fe.short_f, fe.long_f); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL snap_idle: got busy=%b want 0", busy); end
        // A frame with no request must not be written and counters must hold
        w0 = wr_count; d0 = done_count;
        frame_start();
        frame_body(Y, X, 0, n);
        frame_end();
        checks++; if (wr_count - w0 !== 0) begin errors++; $display("[TB] FAIL idle_writes: got %0d want 0", wr_count - w0); end
        checks++; if (done_count - d0 !== 0) begin errors++; $display("[TB] FAIL idle_done: got %0d want 0", done_count - d0); end
        checks++; if (int'(pix_cnt) !== fe.pix) begin errors++; $display("[TB] FAIL idle_pix_hold: got %0d want %0d", pix_cnt, fe.pix); end
    endtask

    task automatic test_snap_mid_frame();
        int w0, d0, n;
        frame_exp_t fe;
        w0 = wr_count; d0 = done_count;
        frame_start();
        pulse_snap();
        frame_body(Y, X, 0, n);
        frame_end();
        checks++; if (wr_count - w0 !== 0) begin errors++; $display("[TB] FAIL mid_partial_writes: got %0d want 0", wr_count - w0); end
        checks++; if (done_count - d0 !== 0) begin errors++; $display("[TB] FAIL mid_partial_done: got %0d want 0", done_count - d0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_still_armed: got busy=%b want 1", busy); end
        w0 = wr_count; d0 = done_count;
        frame_start();
        frame_body(Y, X, 0, n);
        frame_end();
        fe = model_frame(n, Y);
        exp_frame_cnt = (exp_frame_cnt + 1) % 256;
        checks++; if (wr_count - w0 !== fe.wr) begin errors++; $display("[TB] FAIL mid_full_writes: got %0d want %0d", wr_count - w0, fe.wr); end
        checks++; if (done_count - d0 !== 1) begin errors++; $display("[TB] FAIL mid_full_done: got %0d want 1", done_count - d0); end
        checks++; if (int'(frame_cnt) !== exp_frame_cnt) begin errors++; $display("[TB] FAIL mid_frame_cnt: got %0d want %0d", frame_cnt, exp_frame_cnt); end
    endtask

    task automatic test_continuous();
        int w0, d0, n;
        int extras[3] = '{0, -2, 2};
        frame_exp_t fe;
        cont_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            w0 = wr_count; d0 = done_count;
            frame_start();
            if (f == 2) cont_mode = 1'b0;
            frame_body(Y, X, extras[f], n);
            frame_end();
            fe = model_frame(n, Y);
            exp_frame_cnt = (exp_frame_cnt + 1) % 256;
            checks++; if (wr_count - w0 !== fe.wr) begin errors++; $display("[TB] FAIL cont%0d_writes: got %0d want %0d", f, wr_count - w0, fe.wr); end
            checks++; if (done_count - d0 !== 1) begin errors++; $display("[TB] FAIL cont%0d_done: got %0d want 1", f, done_count - d0); end
            checks++; if (int'(pix_cnt) !== fe.pix) begin errors++; $display("[TB] FAIL cont%0d_pix_cnt: got %0d want %0d", f, pix_cnt, fe.pix); end
            checks++; if (err_short !== fe.short_f) begin errors++; $display("[TB] FAIL cont%0d_err_short: got %b want %b", f, err_short, fe.short_f); end
            checks++; if (err_long !== fe.long_f) begin errors++; $display("[TB] FAIL cont%0d_err_long: got %b want %b", f, err_long, fe.long_f); end
        end
        checks++; if (int'(frame_cnt) !== exp_frame_cnt) begin errors++; $display("[TB] FAIL cont_frame_cnt: got %0d want %0d", frame_cnt, exp_frame_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_stop_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_flags_clear();
        int w0, n;
        frame_exp_t fe;
        w0 = wr_count;
        pulse_snap();
        frame_start();
        checks++; if (err_long !== 1'b0 || err_short !== 1'b0) begin errors++; $display("[TB] FAIL clear_flags: got %b%b want 00", err_short, err_long); end
        checks++; if (pix_cnt !== '0 || line_cnt !== 8'd0) begin errors++; $display("[TB] FAIL clear_counts: got pix=%0d lines=%0d want 0 0", pix_cnt, line_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL clear_busy: got %b want 1", busy); end
        frame_body(Y, X, 0, n);
        frame_end();
        fe = model_frame(n, Y);
        exp_frame_cnt = (exp_frame_cnt + 1) % 256;
        checks++; if (wr_count - w0 !== fe.wr) begin errors++; $display("[TB] FAIL clear_writes: got %0d want %0d", wr_count - w0, fe.wr); end
    endtask

    task automatic test_reset_mid_capture();
        int w0, d0, n;
        frame_exp_t fe;
        w0 = wr_count;
        pulse_snap();
        frame_start();
        frame_body(1, 5, 0, n);
        checks++; if (wr_count - w0 !== n) begin errors++; $display("[TB] FAIL rstmid_pre_writes: got %0d want %0d", wr_count - w0, n); end
        rst          = 1'b1;
        pix_valid_in = 1'b1;
        #1;
        checks++; if (DP_RAM_regW !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_regw: got %b want 0", DP_RAM_regW); end
        tick();
        rst          = 1'b0;
        pix_valid_in = 1'b0;
        exp_frame_cnt = 0;
        checks++; if (pix_cnt !== '0 || line_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rstmid_counts: got pix=%0d lines=%0d want 0 0", pix_cnt, line_cnt); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rstmid_frame_cnt: got %0d want 0", frame_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_idle: got busy=%b want 0", busy); end
        w0 = wr_count; d0 = done_count;
        frame_body(2, X, 0, n);
        frame_end();
        checks++; if (wr_count - w0 !== 0 || done_count - d0 !== 0) begin errors++; $display("[TB] FAIL rstmid_after: got writes=%0d done=%0d want 0 0", wr_count - w0, done_count - d0); end
        w0 = wr_count;
        pulse_snap();
        frame_start();
        frame_body(Y, X, 0, n);
        frame_end();
        fe = model_frame(n, Y);
        exp_frame_cnt = (exp_frame_cnt + 1) % 256;
        checks++; if (wr_count - w0 !== fe.wr) begin errors++; $display("[TB] FAIL rstmid_recover_writes: got %0d want %0d", wr_count - w0, fe.wr); end
        checks++; if (int'(frame_cnt) !== exp_frame_cnt) begin errors++; $display("[TB] FAIL rstmid_recover_cnt: got %0d want %0d", frame_cnt, exp_frame_cnt); end
    endtask

    task automatic test_line_saturation();
        int w0;
        frame_exp_t fe;
        w0 = wr_count;
        pulse_snap();
        frame_start();
        for (int l = 0; l < 260; l++) begin
            CAM_href = 1'b1;
            tick();
            CAM_href = 1'b0;
            tick();
        end
        frame_end();
        fe = model_frame(0, 260);
        exp_frame_cnt = (exp_frame_cnt + 1) % 256;
        checks++; if (int'(line_cnt) !== fe.lines) begin errors++; $display("[TB] FAIL sat_line_cnt: got %0d want %0d", line_cnt, fe.lines); end
        checks++; if (err_short !== fe.short_f || err_long !== fe.long_f) begin errors++; $display("[TB] FAIL sat_errs: got %b%b want %b%b", err_short, err_long, fe.short_f, fe.long_f); end
        checks++; if (wr_count - w0 !== fe.wr) begin errors++; $display("[TB] FAIL sat_writes: got %0d want %0d", wr_count - w0, fe.wr); end
    endtask

    task automatic test_wrap();
        int d0, frames;
        frames = 0;
        d0 = done_count;
        cont_mode = 1'b1;
        tick();
        while (exp_frame_cnt != 255) begin
            CAM_vsync = 1'b0;
            repeat ($urandom_range(2, 3)) tick();
            CAM_vsync = 1'b1;
            repeat (3) tick();
            exp_frame_cnt++;
            frames++;
        end
        checks++; if (done_count - d0 !== frames) begin errors++; $display("[TB] FAIL wrap_done_total: got %0d want %0d", done_count - d0, frames); end
        checks++; if (int'(frame_cnt) !== 255) begin errors++; $display("[TB] FAIL wrap_pre: got %0d want 255", frame_cnt); end
        d0 = done_count;
        CAM_vsync = 1'b0;
        tick();
        cont_mode = 1'b0;
        tick();
        CAM_vsync = 1'b1;
        repeat (3) tick();
        exp_frame_cnt = (exp_frame_cnt + 1) % 256;
        checks++; if (int'(frame_cnt) !== exp_frame_cnt) begin errors++; $display("[TB] FAIL wrap_cnt: got %0d want %0d", frame_cnt, exp_frame_cnt); end
        checks++; if (done_count - d0 !== 1) begin errors++; $display("[TB] FAIL wrap_done: got %0d want 1", done_count - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wrap_idle: got busy=%b want 0", busy); end
    endtask

`ifdef CAPTURE_WDOG_EN
    task automatic test_watchdog();
        int w0, d0, n;
        d0 = done_count;
        CAM_vsync = 1'b1;
        pulse_snap();
        repeat (TMO - 1) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL wdog_before: got busy=%b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wdog_idle: got busy=%b want 0", busy); end
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("[TB] FAIL wdog_flag: got %b want 1", err_timeout); end
        checks++; if (int'(frame_cnt) !== exp_frame_cnt || done_count - d0 !== 0) begin errors++; $display("[TB] FAIL wdog_no_frame: got cnt=%0d done=%0d want %0d 0", frame_cnt, done_count - d0, exp_frame_cnt); end
        w0 = wr_count;
        pulse_snap();
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL wdog_clear: got %b want 0", err_timeout); end
        frame_start();
        frame_body(Y, X, 0, n);
        frame_end();
        exp_frame_cnt = (exp_frame_cnt + 1) % 256;
        checks++; if (wr_count - w0 !== IMA) begin errors++; $display("[TB] FAIL wdog_frame_writes: got %0d want %0d", wr_count - w0, IMA); end
    endtask
`endif

    initial begin
        test_reset();
        test_snapshot();
        test_snap_mid_frame();
        test_continuous();
        test_flags_clear();
        test_reset_mid_capture();
`ifndef CAPTURE_WDOG_EN
        test_line_saturation();
`endif
        test_wrap();
`ifdef CAPTURE_WDOG_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Frame-capture sequencer between cam_read and buffer_ram_dp, running in the camera pixel-clock domain. Gates the DP_RAM write enable so that only whole, frame-aligned QQVGA frames are written, in single-shot (snapshot) or continuous mode. Counts pixels and lines per frame, flags short and long frames, and reports a frame counter for status/LEDs.

Parameters:
CAM_SCREEN_X, 160, pixels per line
CAM_SCREEN_Y, 120, lines per frame
AW, 15, RAM address width; imaSiz = CAM_SCREEN_X*CAM_SCREEN_Y must be < 2^AW
TIMEOUT_CYC, 2000000, watchdog limit in clk cycles (used only with the optional feature)

Ports:
clk  in  1  pixel clock (driven by CAM_pclk)
rst  in  1  synchronous reset, active-high
CAM_vsync  in  1  camera VSYNC (high between frames)
CAM_href  in  1  camera HREF (high during valid line)
pix_valid_in  in  1  pixel-complete strobe from cam_read (its DP_RAM_regW)
snap  in  1  single-frame capture request, level or pulse
cont_mode  in  1  1 = capture every frame continuously
DP_RAM_regW  out  1  gated write enable to buffer_ram_dp
busy  out  1  1 in ARM or CAPTURE
frame_done  out  1  one-cycle pulse at end of captured frame
frame_cnt  out  8  completed-frame counter
pix_cnt  out  AW  pixels accepted in current/last frame
line_cnt  out  8  href falling edges in current/last frame
err_short  out  1  last frame had fewer than imaSiz pixels
err_long  out  1  last frame delivered more than imaSiz pixels (excess dropped)

Behaviour:
- Edge detect: vsync_q, href_q registered each cycle; vs_fall = vsync_q & ~CAM_vsync; vs_rise = ~vsync_q & CAM_vsync; href_fall = href_q & ~CAM_href.
- States: IDLE, ARM, CAPTURE, DONE. Encoding is free.
- IDLE: gate off. snap|cont_mode -> ARM next edge.
- ARM: gate off. vs_fall -> CAPTURE. Entering CAPTURE clears pix_cnt, line_cnt, err_short, err_long.
- CAPTURE:
  - DP_RAM_regW = pix_valid_in & (pix_cnt < imaSiz), combinational from the registered state and counters; zero latency relative to pix_valid_in.
  - Each accepted pixel increments pix_cnt.
  - pix_valid_in while pix_cnt == imaSiz: not written; err_long set.
  - href_fall increments line_cnt, saturating at 255.
  - vs_rise -> DONE; err_short set if pix_cnt < imaSiz, evaluated before any same-cycle increment is lost (increment counts).
- DONE, exactly 1 cycle:
  - frame_done = 1; frame_cnt += 1, wrapping 255 -> 0.
  - Next state: cont_mode|snap -> ARM, else IDLE.
- snap is ignored in ARM and CAPTURE; it is not queued.
- cont_mode deasserted mid-CAPTURE: the current frame completes, then IDLE.
- vs_fall and vs_rise cannot coincide; vsync toggling in ARM before a fall is ignored.
- Reset values: state IDLE; DP_RAM_regW 0 (forced 0 combinationally while rst = 1); busy 0; frame_done 0; frame_cnt 0; pix_cnt 0; line_cnt 0; err_short 0; err_long 0; vsync_q 1; href_q 0.
- Reset mid-CAPTURE: all outputs take reset values at the next edge; no write is issued in the reset cycle.
- pix_cnt, line_cnt and error flags hold their values through DONE and IDLE until the next CAPTURE entry.

Optional Feature:
CAPTURE_WDOG_EN
- Defined: a cycle counter runs in ARM and CAPTURE and clears on every vs_fall/vs_rise. On reaching TIMEOUT_CYC-1 the block goes to IDLE. Added output err_timeout (1 bit) is set sticky and cleared by rst or the next entry to ARM. frame_done is not pulsed and frame_cnt is unchanged.
- Undefined: no counter, no err_timeout port; ARM and CAPTURE wait indefinitely.

Test Plan:
- X=4, Y=3, snap pulse, vsync high then low, 3 lines of 4 pix_valid, vsync high -> exactly 12 DP_RAM_regW pulses, frame_done once, frame_cnt=1, pix_cnt=12, line_cnt=3, no errors, ends in IDLE.
- Same setup, snap asserted mid-frame (vsync already low) -> no writes until the next vs_fall; the following full frame is captured.
- cont_mode=1 for 3 frames, second frame has 10 pixels, third has 14 -> frame_cnt=3; err_short after frame 2; err_long after frame 3 with only 12 writes; flags clear on next CAPTURE entry.
- rst pulsed for 1 cycle after 5 pixels in CAPTURE -> DP_RAM_regW 0 during rst; all counters 0, state IDLE; no writes until the next snap and vs_fall.
- frame_cnt preset by 255 continuous frames, one more frame -> frame_cnt wraps to 0 with frame_done pulse.
- CAPTURE_WDOG_EN, TIMEOUT_CYC=50, snap with vsync held high -> IDLE after 50 cycles, err_timeout=1, frame_cnt unchanged.
